// File: rtl/pipelined_addsub_if.sv
// Handshake and operand/result bundle for pipelined_addsub.
// master drives operations and result acceptance; slave is the arithmetic unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with carry-in; the carry chain is cut into CHUNK-bit registered slices.
// Define PIPELINED_ADDSUB_OVF_EN to build the registered signed-overflow output (tied to 0 otherwise).
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic [STAGES-1:0] w_adv;
  logic [WIDTH-1:0]  w_bx;
  logic              w_c0;

  assign w_bx         = bus.b ^ {WIDTH{bus.sub}};
  assign w_c0         = bus.cin ^ bus.sub;
  assign bus.in_ready = w_adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * CHUNK;
    localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
    localparam int SW = HI - LO + 1;

    logic              r_vld;
    logic              r_c;
    logic [HI:0]       r_sum;
    logic              w_vin;
    logic              w_cin;
    logic              w_unl;
    logic [WIDTH-1:LO] w_ain;
    logic [WIDTH-1:LO] w_bin;
    logic [HI:0]       w_snxt;
    logic [SW:0]       w_slice;

    if (s == 0) begin : g_head
      assign w_vin  = bus.in_valid;
      assign w_cin  = w_c0;
      assign w_ain  = bus.a;
      assign w_bin  = w_bx;
      assign w_snxt = w_slice[SW-1:0];
    end else begin : g_body
      assign w_vin  = g_st[s-1].r_vld;
      assign w_cin  = g_st[s-1].r_c;
      assign w_ain  = g_st[s-1].g_keep.r_a;
      assign w_bin  = g_st[s-1].g_keep.r_b;
      assign w_snxt = {w_slice[SW-1:0], g_st[s-1].r_sum};
    end

    // Only this slice ripples; upper operand bits wait in g_keep for later stages.
    assign w_slice = {1'b0, w_ain[HI:LO]} + {1'b0, w_bin[HI:LO]} + {{SW{1'b0}}, w_cin};

    if (s == STAGES - 1) begin : g_tail
      assign w_unl = r_vld & bus.out_ready;
    end else begin : g_mid
      assign w_unl = r_vld & w_adv[s+1];
    end

    // An empty stage always refills, so bubbles collapse under a downstream stall.
    assign w_adv[s] = ~r_vld | w_unl;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv[s]) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_c   <= w_slice[SW];
          r_sum <= w_snxt;
        end
      end
    end

    if (s < STAGES - 1) begin : g_keep
      logic [WIDTH-1:HI+1] r_a;
      logic [WIDTH-1:HI+1] r_b;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv[s] && w_vin) begin
          r_a <= w_ain[WIDTH-1:HI+1];
          r_b <= w_bin[WIDTH-1:HI+1];
        end
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].r_vld;
  assign bus.sum       = g_st[STAGES-1].r_sum;
  assign bus.cout      = g_st[STAGES-1].r_c;

`ifdef PIPELINED_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Operand signs are still present at the last stage's input, so only the flag itself is registered.
  assign w_ovf = (g_st[STAGES-1].w_ain[WIDTH-1] == g_st[STAGES-1].w_bin[WIDTH-1]) &
                 (g_st[STAGES-1].w_snxt[WIDTH-1] != g_st[STAGES-1].w_ain[WIDTH-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv[STAGES-1] && g_st[STAGES-1].w_vin) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: an 8-bit/4-bit-chunk unit and a 7-bit/3-bit-chunk unit checked
// against a plain-arithmetic reference queue, plus directed literal cases.
module tb_pipelined_addsub;
`ifdef PIPELINED_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pipelined_addsub_if #(.WIDTH(8)) ifa ();
  pipelined_addsub_if #(.WIDTH(7)) ifb ();

  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  pipelined_addsub #(.WIDTH(7), .CHUNK(3)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));

  int   nt = 0;
  int   nf = 0;
  int   popa = 0;
  int   popb = 0;
  res_t qa[$];
  res_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full-precision integer sum, signed overflow by range check.
  function automatic res_t model(input int w, input int a, input int b, input int cin, input int sub);
    int   m, bp, c0, t, half, sa, sb, sv;
    res_t r;
    m    = (1 << w) - 1;
    bp   = (sub != 0) ? (~b & m) : (b & m);
    c0   = (cin ^ sub) & 1;
    t    = (a & m) + bp + c0;
    half = 1 << (w - 1);
    sa   = ((a & m) >= half) ? (a & m) - (1 << w) : (a & m);
    sb   = (bp >= half) ? bp - (1 << w) : bp;
    sv   = sa + sb + c0;
    r.s  = 8'(t & m);
    r.c  = ((t >> w) & 1) != 0;
    r.o  = OVF_ON && (sv >= half || sv < -half);
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ifa.out_valid) begin
        if (qa.size() == 0) chk("a_out_unexpected", 32'(ifa.out_valid), 32'd0);
        else begin
          chk("a_sum", 32'(ifa.sum), 32'(qa[0].s));
          chk("a_cout", 32'(ifa.cout), 32'(qa[0].c));
          chk("a_ovf", 32'(ifa.ovf), 32'(qa[0].o));
          if (ifa.out_ready) begin
            void'(qa.pop_front());
            popa++;
          end
        end
      end
      if (ifb.out_valid) begin
        if (qb.size() == 0) chk("b_out_unexpected", 32'(ifb.out_valid), 32'd0);
        else begin
          chk("b_sum", 32'(ifb.sum), 32'(qb[0].s));
          chk("b_cout", 32'(ifb.cout), 32'(qb[0].c));
          chk("b_ovf", 32'(ifb.ovf), 32'(qb[0].o));
          if (ifb.out_ready) begin
            void'(qb.pop_front());
            popb++;
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready)
        qa.push_back(model(8, int'(ifa.a), int'(ifa.b), int'(ifa.cin), int'(ifa.sub)));
      if (ifb.in_valid && ifb.in_ready)
        qb.push_back(model(7, int'(ifb.a), int'(ifb.b), int'(ifb.cin), int'(ifb.sub)));
    end
  end

  task automatic set_op(input int sel, input int a, input int b, input int cin, input int sub);
    if (sel == 0) begin
      ifa.a = 8'(a); ifa.b = 8'(b); ifa.cin = 1'(cin); ifa.sub = 1'(sub);
    end else begin
      ifb.a = 7'(a); ifb.b = 7'(b); ifb.cin = 1'(cin); ifb.sub = 1'(sub);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic drive(input int sel, input int a, input int b, input int cin, input int sub);
    bit ok = 1'b0;
    set_op(sel, a, b, cin, sub);
    if (sel == 0) ifa.in_valid = 1'b1; else ifb.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ((sel == 0) ? ifa.in_ready : ifb.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    if (sel == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic dir(input int sel, input string nm, input int a, input int b, input int cin,
                     input int sub, input int es, input int ec, input int eo);
    int lat;
    lat = (sel == 0) ? 2 : 3;
    @(posedge clock);
    #1;
    drive(sel, a, b, cin, sub);
    for (int i = 0; i < lat - 1; i++) begin
      @(negedge clock);
      chk({nm, "_early"}, 32'((sel == 0) ? ifa.out_valid : ifb.out_valid), 32'd0);
    end
    @(negedge clock);
    if (sel == 0) begin
      chk({nm, "_vld"}, 32'(ifa.out_valid), 32'd1);
      chk({nm, "_sum"}, 32'(ifa.sum), 32'(es));
      chk({nm, "_cout"}, 32'(ifa.cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ifa.ovf), 32'(eo));
    end else begin
      chk({nm, "_vld"}, 32'(ifb.out_valid), 32'd1);
      chk({nm, "_sum"}, 32'(ifb.sum), 32'(es));
      chk({nm, "_cout"}, 32'(ifb.cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ifb.ovf), 32'(eo));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pa0;
    ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
    set_op(0, 8'h3C, 8'h11, 1, 0);
    set_op(1, 7'h2A, 7'h15, 0, 1);
    reset_n = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_a_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_a_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_a_sum", 32'(ifa.sum), 32'd0);
    chk("rst_a_cout", 32'(ifa.cout), 32'd0);
    chk("rst_a_ovf", 32'(ifa.ovf), 32'd0);
    chk("rst_b_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("rst_b_in_ready", 32'(ifb.in_ready), 32'd1);

    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;

    dir(0, "add_ripple", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    dir(0, "sub_borrow", 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0);
    dir(0, "sub_noborrow", 8'h07, 8'h05, 0, 1, 8'h02, 1, 0);
    dir(0, "add_ovf", 8'h7F, 8'h01, 0, 0, 8'h80, 0, OVF_ON ? 1 : 0);
    dir(0, "sub_ovf", 8'h80, 8'h01, 0, 1, 8'h7F, 1, OVF_ON ? 1 : 0);
    dir(0, "add_cin", 8'h10, 8'h20, 1, 0, 8'h31, 0, 0);

    // Backpressure: six back-to-back ops against a stalled consumer.
    @(posedge clock);
    #1;
    pa0 = popa;
    acc = 0;
    ifa.out_ready = 1'b0;
    set_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
    ifa.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (ifa.in_ready) acc++;
      @(posedge clock);
      #1;
      set_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 100 && acc < 6; c++) begin
      @(negedge clock);
      if (ifa.in_ready) acc++;
      @(posedge clock);
      #1;
      set_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    ifa.in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("bp_all_accepted", 32'(acc), 32'd6);
    chk("bp_results_out", 32'(popa - pa0), 32'd6);

    // Random traffic on both units with random consumer stalls.
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      ifa.in_valid  = ($urandom_range(0, 3) != 0);
      ifb.in_valid  = ($urandom_range(0, 3) != 0);
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      ifb.out_ready = ($urandom_range(0, 2) != 0);
      set_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
      set_op(1, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    @(posedge clock);
    #1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    repeat (8) @(negedge clock);
    chk("rand_a_drained", 32'(qa.size()), 32'd0);
    chk("rand_b_drained", 32'(qb.size()), 32'd0);
    chk("rand_a_some_out", 32'(popa > 50), 32'd1);
    chk("rand_b_some_out", 32'(popb > 50), 32'd1);

    // Mid-flight reset on the 3-stage unit.
    @(posedge clock);
    #1;
    ifb.out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      drive(1, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1));
    #2;
    chk("pre_rst_b_full", 32'(ifb.out_valid), 32'd1);
    chk("pre_rst_b_in_ready", 32'(ifb.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_async_b_vld", 32'(ifb.out_valid), 32'd0);
    chk("rst_async_b_in_ready", 32'(ifb.in_ready), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    ifb.out_ready = 1'b1;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rst_no_stale_b", 32'(ifb.out_valid), 32'd0);
    end
    dir(1, "w7_ripple", 7'h7F, 7'h01, 0, 0, 7'h00, 1, 0);
    dir(1, "w7_sub", 7'h03, 7'h05, 0, 1, 7'h7E, 0, 0);

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two-operand add/subtract unit with carry-in. It generalises the team's fixed 3-bit carry-in adder to any width. The carry chain is split into CHUNK-bit slices, with one pipeline register per slice, and a valid/ready handshake on both sides. It sits between operand producers and result consumers in the arithmetic datapath and accepts one operation per cycle at full throughput.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; must be ≥1.
- `CHUNK`, default 4: bits resolved per pipeline stage; 1 ≤ CHUNK ≤ WIDTH.
- Derived: `STAGES` = ceil(WIDTH/CHUNK). The top slice is WIDTH − (STAGES−1)·CHUNK bits wide.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the unit accepts this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in (add) or carry-in of the inverted-B form (sub).
- `sub` in 1: 0 = add, 1 = subtract.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: the consumer accepts this cycle.
- `sum` out WIDTH: result.
- `cout` out 1: carry out of the MSB.
- `ovf` out 1: signed overflow (see Configuration).

## Operation
- Result = a + (b ^ {WIDTH{sub}}) + (cin ^ sub), computed mod 2^(WIDTH+1).
  - `sum` = low WIDTH bits; `cout` = bit WIDTH.
  - With `sub=1`, `cin=0` gives a − b. `cout=1` means no borrow.
- Stage s (0..STAGES−1) adds slice s of A and B′ using the carry registered by stage s−1; stage 0 uses `cin ^ sub`.
- Each stage register holds:
  - its valid bit;
  - the sum slices already resolved;
  - the unresolved upper slices of A and B′;
  - the slice carry-out;
  - the MSB operand signs needed for `ovf`.
- Stage advance rule: stage s loads from stage s−1 when stage s is empty or stage s is unloading this cycle.
  - The last stage unloads on `out_valid & out_ready`.
  - `in_ready` = stage 0 empty or stage 0 unloading. It is combinational from stage valids and `out_ready` only, never from `in_valid`.
- Bubbles collapse: an empty stage refills even while downstream is stalled.
- Transfers occur only on valid&ready. Results leave in acceptance order; none are dropped or duplicated.
- `sum`/`cout`/`ovf` hold stable while `out_valid=1` and `out_ready=0`.
- `a`, `b`, `cin`, `sub` are sampled only on an accepted cycle. They are don't-care otherwise.

## Timing
- Reset (asserted asynchronously, released synchronously by the bench): all stage valids 0. While in reset and after it:
  - `out_valid`=0, `in_ready`=1;
  - `sum`=0, `cout`=0, `ovf`=0;
  - all data registers 0.
- Latency: an operation accepted at edge k presents `out_valid=1` after edge k+STAGES−1 and before edge k+STAGES, given no stall.
  - STAGES=1 gives a single registered stage.
- Throughput: 1 op/cycle with `out_ready` held high.
- Capacity: STAGES operations in flight. With `out_ready=0`, exactly STAGES further accepts occur, then `in_ready=0`.
- Simultaneous unload and load on a full pipe: both happen in the same cycle and `in_ready` stays 1.
- Reset mid-operation discards all in-flight results. No partial result appears after reset deassertion.
- Carry path per cycle: at most CHUNK bits of ripple plus one register.

## Configuration
- Macro: `PIPELINED_ADDSUB_OVF_EN`.
- When defined:
  - `ovf` = (A_msb == B′_msb) & (sum_msb != A_msb), computed in the last stage;
  - `ovf` is registered alongside `sum`.
- When undefined:
  - the port exists but is tied to 0;
  - no sign-tracking registers are built.

## Test plan
WIDTH=8, CHUNK=4 (STAGES=2) unless noted.
- Reset: hold `reset_n=0` for 3 cycles with `in_valid=1` → `out_valid=0`, `in_ready=1`, `sum=0`, `cout=0`, `ovf=0`. First accept after release yields `out_valid` 2 edges later.
- Add carry ripple across slices: a=8'hFF, b=8'h01, cin=0, sub=0 → `sum`=8'h00, `cout`=1, `ovf`=0 (macro on), 2 cycles after accept.
- Subtract with borrow: a=8'h05, b=8'h07, sub=1, cin=0 → `sum`=8'hFE, `cout`=0. a=8'h07, b=8'h05 → `sum`=8'h02, `cout`=1.
- Overflow: a=8'h7F, b=8'h01, add → `sum`=8'h80, `ovf`=1 with the macro and `ovf`=0 without it. a=8'h80, b=8'h01, sub → `sum`=8'h7F, `ovf`=1 with the macro.
- Backpressure: drive 6 back-to-back ops with `out_ready=0` for 5 cycles → exactly 2 accepted, then `in_ready=0`. After `out_ready=1`, all 6 results emerge in order with correct values and `sum` stable while stalled.
- Reset mid-flight plus odd width: WIDTH=7, CHUNK=3 (STAGES=3, top slice 1 bit). Accept 3 ops, assert `reset_n=0` asynchronously mid-cycle → `out_valid` falls immediately and none of the 3 results ever appears. Then 7'h7F+7'h01 → `sum`=7'h00, `cout`=1 after 3 cycles.
